noise_sound_mc: RTL and testbench

//  Multi-channel noise sound generator, successor to the single-channel noise voice.
//  - Noise source: one shared 17-bit LFSR.
//  - Per channel: triggerable decaying envelope with loud/soft peak, plus a one-pole IIR low-pass.
//  - Filter is time-multiplexed over channels; channel products are mixed into one saturated sample.
//  - Sits between the sound-latch decode and the audio mixer (explosion, shell and engine noise voices).

---
 rtl/noise_sound_pkg.sv | 20 ++
 rtl/noise_lfsr.sv | 28 ++
 rtl/noise_sound_mc.sv | 205 ++++++++++++++++++++
 tb/tb_noise_sound_mc.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/noise_sound_pkg.sv
// rtl/noise_sound_pkg.sv - shared types, LFSR constants and saturation helper for the noise voices
package noise_sound_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DECAY = 1'b1
    } env_state_t;

    localparam logic [16:0] LFSR_SEED  = 17'h1;
    localparam int          LFSR_TAP_A = 16;
    localparam int          LFSR_TAP_B = 13;

    // Unsigned clamp of an accumulator to the largest w-bit value.
    function automatic logic [31:0] sat_u(input logic [31:0] acc, input int w);
        logic [31:0] lim;
        lim = (32'd1 << w) - 32'd1;
        return (acc > lim) ? lim : acc;
    endfunction

endpackage

// File: rtl/noise_lfsr.sv
// rtl/noise_lfsr.sv - 17-bit Fibonacci LFSR noise source, shift gated by clk_en
module noise_lfsr
    import noise_sound_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic clk_en,
    output logic noise
);

    logic [16:0] q;

    // The all-zero lock-up state is escaped by reseeding instead of shifting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= LFSR_SEED;
        end else if (clk_en) begin
            if (q == '0) begin
                q <= LFSR_SEED;
            end else begin
                q <= {q[15:0], q[LFSR_TAP_A] ^ q[LFSR_TAP_B]};
            end
        end
    end

    assign noise = q[0];

endmodule

// File: rtl/noise_sound_mc.sv
// rtl/noise_sound_mc.sv - multi-channel noise voice: envelopes, time-shared IIR filter and saturating mixer
module noise_sound_mc
    import noise_sound_pkg::*;
#(
    parameter int NUM_CH          = 2,
    parameter int OUT_W           = 16,
    parameter int ENV_W           = 16,
    parameter int FILTER_STRENGTH = 7,
    parameter int DECAY_STEP      = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clk_3MHz_en,
    input  logic              clk_en,
    input  logic [NUM_CH-1:0] trig,
    input  logic [NUM_CH-1:0] loud_soft,
    output logic [NUM_CH-1:0] busy,
    output logic [OUT_W-1:0]  out
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ACC_W = OUT_W + $clog2(NUM_CH) + 1;
    localparam int PRD_W = OUT_W + ENV_W;

    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [OUT_W-1:0] X_HI      = OUT_W'(1) << (OUT_W - 4);
    localparam logic [ENV_W-1:0] PEAK_LOUD = '1;
    localparam logic [ENV_W-1:0] PEAK_SOFT = {1'b0, {(ENV_W-1){1'b1}}};
    localparam logic [ENV_W-1:0] STEP      = ENV_W'(DECAY_STEP);

    logic noise;

    noise_lfsr u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .clk_en  (clk_en),
        .noise   (noise)
    );

    env_state_t       st     [NUM_CH];
    env_state_t       st_nx  [NUM_CH];
    logic [ENV_W-1:0] amp    [NUM_CH];
    logic [ENV_W-1:0] amp_nx [NUM_CH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                st[c]  <= IDLE;
                amp[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                st[c]  <= st_nx[c];
                amp[c] <= amp_nx[c];
            end
        end
    end

    // A held trigger pins the envelope at its peak on every tick.
    always_comb begin
        busy = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            st_nx[c]  = st[c];
            amp_nx[c] = amp[c];
            if (clk_3MHz_en) begin
                if (trig[c]) begin
                    amp_nx[c] = loud_soft[c] ? PEAK_LOUD : PEAK_SOFT;
                    st_nx[c]  = DECAY;
                end else if (st[c] == DECAY) begin
                    if (amp[c] <= STEP) begin
                        amp_nx[c] = '0;
                        st_nx[c]  = IDLE;
                    end else begin
                        amp_nx[c] = amp[c] - STEP;
                    end
                end
            end
            busy[c] = (st[c] == DECAY);
        end
    end

    logic              pending;
    logic              issue_on;
    logic [CH_W-1:0]   issue_ch;
    logic              sweep_noise;
    logic              start;
    logic              s1_go;
    logic [CH_W-1:0]   s1_ch;
    logic              s1_noise;
    logic [OUT_W-1:0]  y_rd;

    logic              p1_valid;
    logic [CH_W-1:0]   p1_ch;
    logic [OUT_W-1:0]  p1_x;
    logic [OUT_W-1:0]  p1_y;
    logic [ENV_W-1:0]  p1_amp;

    logic              p2_valid;
    logic              p2_first;
    logic              p2_last;
    logic [OUT_W-1:0]  p2_y;
    logic [ENV_W-1:0]  p2_amp;

    logic              p3_last;
    logic [ACC_W-1:0]  acc;

    logic [OUT_W-1:0]  y_mem [NUM_CH];

    logic signed [OUT_W:0] diff;
    logic signed [OUT_W:0] y_sum;
    logic [OUT_W-1:0]      y_new;
    logic [PRD_W-1:0]      prod_full;
    logic [OUT_W-1:0]      prod;

    // A new sweep may begin as soon as the previous one has issued its last channel.
    assign start    = pending && !issue_on;
    assign s1_go    = start || issue_on;
    assign s1_ch    = start ? '0 : issue_ch;
    assign s1_noise = start ? noise : sweep_noise;

    // Forward the value S2 is writing this cycle so back-to-back sweeps never read a stale state.
    assign y_rd = (p1_valid && (p1_ch == s1_ch)) ? y_new : y_mem[s1_ch];

    always_comb begin
        diff  = $signed({1'b0, p1_x}) - $signed({1'b0, p1_y});
        y_sum = $signed({1'b0, p1_y}) + (diff >>> FILTER_STRENGTH);
        if (y_sum < 0) begin
            y_new = '0;
        end else if (y_sum > $signed({1'b0, X_HI})) begin
            y_new = X_HI;
        end else begin
            y_new = y_sum[OUT_W-1:0];
        end
    end

    assign prod_full = PRD_W'(p2_y) * PRD_W'(p2_amp);
    assign prod      = OUT_W'(prod_full >> ENV_W);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending     <= 1'b0;
            issue_on    <= 1'b0;
            issue_ch    <= '0;
            sweep_noise <= 1'b0;
            p1_valid    <= 1'b0;
            p1_ch       <= '0;
            p1_x        <= '0;
            p1_y        <= '0;
            p1_amp      <= '0;
            p2_valid    <= 1'b0;
            p2_first    <= 1'b0;
            p2_last     <= 1'b0;
            p2_y        <= '0;
            p2_amp      <= '0;
            p3_last     <= 1'b0;
            acc         <= '0;
            out         <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                y_mem[c] <= '0;
            end
        end else begin
            pending <= clk_3MHz_en || (pending && !start);

            if (start) begin
                issue_on    <= (NUM_CH > 1);
                issue_ch    <= CH_W'(1);
                sweep_noise <= noise;
            end else if (issue_on) begin
                if (issue_ch == LAST_CH) begin
                    issue_on <= 1'b0;
                end else begin
                    issue_ch <= issue_ch + CH_W'(1);
                end
            end

            // S1: latch drive, state and envelope for one channel.
            p1_valid <= s1_go;
            p1_ch    <= s1_ch;
            p1_x     <= s1_noise ? X_HI : '0;
            p1_y     <= y_rd;
            p1_amp   <= amp[s1_ch];

            // S2: filter update and write-back.
            if (p1_valid) begin
                y_mem[p1_ch] <= y_new;
            end
            p2_valid <= p1_valid;
            p2_first <= (p1_ch == '0);
            p2_last  <= (p1_ch == LAST_CH);
            p2_y     <= y_new;
            p2_amp   <= p1_amp;

            // S3: scale by the envelope and mix.
            if (p2_valid) begin
                acc <= (p2_first ? '0 : acc) + ACC_W'(prod);
            end
            p3_last <= p2_valid && p2_last;

            if (p3_last) begin
                out <= OUT_W'(sat_u(32'(acc), OUT_W));
            end
        end
    end

endmodule

// File: tb/tb_noise_sound_mc.sv
// tb/tb_noise_sound_mc.sv - directed bench for noise_sound_mc
module tb_noise_sound_mc;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk_3MHz_en;
    logic        clk_en;
    logic [1:0]  trig;
    logic [1:0]  loud_soft;
    logic [1:0]  busy;
    logic [15:0] out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    noise_sound_mc dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clk_3MHz_en (clk_3MHz_en),
        .clk_en      (clk_en),
        .trig        (trig),
        .loud_soft   (loud_soft),
        .busy        (busy),
        .out         (out)
    );

    typedef struct {
        logic [1:0]  trig;
        logic [1:0]  loud;
        int          ticks;
        logic [15:0] amp0;
        logic [15:0] amp1;
        logic [1:0]  busy;
    } env_vec_t;

    env_vec_t vecs [8];
    int       exp_out [700];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        clk_3MHz_en = 1'b0;
        clk_en      = 1'b0;
        trig        = 2'b00;
        loud_soft   = 2'b00;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            clk_3MHz_en = 1'b1;
            step();
            clk_3MHz_en = 1'b0;
            step();
        end
    endtask

    function automatic int filt(input int y);
        return y + ((4096 - y) >>> 7);
    endfunction

    function automatic logic [16:0] lfsr_next(input logic [16:0] q);
        if (q == 17'h0) return 17'h1;
        return {q[15:0], q[16] ^ q[13]};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [16:0] m;
        int          y;

        vecs[0] = '{2'b01, 2'b01, 1,    16'hFFFF, 16'h0000, 2'b01};
        vecs[1] = '{2'b00, 2'b00, 1023, 16'd63,   16'h0000, 2'b01};
        vecs[2] = '{2'b00, 2'b00, 1,    16'h0000, 16'h0000, 2'b00};
        vecs[3] = '{2'b10, 2'b00, 1,    16'h0000, 16'h7FFF, 2'b10};
        vecs[4] = '{2'b00, 2'b00, 100,  16'h0000, 16'd26367, 2'b10};
        vecs[5] = '{2'b10, 2'b00, 1,    16'h0000, 16'h7FFF, 2'b10};
        vecs[6] = '{2'b10, 2'b10, 3,    16'h0000, 16'hFFFF, 2'b10};
        vecs[7] = '{2'b00, 2'b00, 1024, 16'h0000, 16'h0000, 2'b00};

        // Reset state and LFSR sequence.
        do_reset();
        check("rst_out", 32'(out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_lfsr", 32'(dut.u_lfsr.q), 32'd1);
        m = 17'h1;
        for (int i = 0; i < 20; i++) begin
            clk_en = 1'b1;
            step();
            m = lfsr_next(m);
            check($sformatf("lfsr_%0d", i), 32'(dut.u_lfsr.q), 32'(m));
        end
        clk_en = 1'b0;

        // Envelope vectors.
        do_reset();
        for (int v = 0; v < 8; v++) begin
            trig      = vecs[v].trig;
            loud_soft = vecs[v].loud;
            tick(vecs[v].ticks);
            trig = 2'b00;
            check($sformatf("env%0d_amp0", v), 32'(dut.amp[0]), 32'(vecs[v].amp0));
            check($sformatf("env%0d_amp1", v), 32'(dut.amp[1]), 32'(vecs[v].amp1));
            check($sformatf("env%0d_busy", v), 32'(busy), 32'(vecs[v].busy));
        end

        // Noise held at 1 (LFSR never shifts); both channels pinned loud; enable every 3 clks.
        do_reset();
        trig      = 2'b11;
        loud_soft = 2'b11;
        y = 0;
        for (int i = 0; i < 700; i++) begin
            y = filt(y);
            exp_out[i] = 2 * ((y * 65535) >>> 16);
        end
        for (int i = 0; i < 700; i++) begin
            clk_3MHz_en = 1'b1;
            step();
            clk_3MHz_en = 1'b0;
            step();
            if (i < 12) check($sformatf("lat_a_%0d", i), 32'(out), (i >= 2) ? 32'(exp_out[i-2]) : 32'd0);
            step();
            if (i < 12) check($sformatf("lat_b_%0d", i), 32'(out), (i >= 1) ? 32'(exp_out[i-1]) : 32'd0);
        end
        repeat (6) step();
        check("conv_model", 32'(out), 32'(exp_out[699]));
        check("conv_out", 32'(out), 32'd7936);

        // Asynchronous reset during S2 of channel 1.
        clk_3MHz_en = 1'b1;
        step();
        clk_3MHz_en = 1'b0;
        step();
        step();
        reset_n = 1'b0;
        #1;
        check("midrst_out", 32'(out), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        trig      = 2'b01;
        loud_soft = 2'b01;
        step();
        reset_n = 1'b1;
        check("midrst_lfsr", 32'(dut.u_lfsr.q), 32'd1);
        repeat (8) step();
        check("no_ghost_out", 32'(out), 32'd0);

        // Enable arriving mid-sweep queues exactly one extra sweep.
        clk_3MHz_en = 1'b1;
        step();
        step();
        clk_3MHz_en = 1'b0;
        step();
        step();
        step();
        check("pend_e4", 32'(out), 32'd0);
        step();
        check("pend_e5", 32'(out), 32'd31);
        step();
        check("pend_e6", 32'(out), 32'd31);
        step();
        check("pend_e7", 32'(out), 32'd62);
        repeat (4) step();
        check("pend_hold", 32'(out), 32'd62);
        check("pend_busy", 32'(busy), 32'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
